// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ requesters.
// Each grant lasts up to BURST_LEN words; fifo_full stalls the owner in place.
module fifo_write_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned REQ_BITS   = 2,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned BURST_BITS = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  input  logic                          fifo_full,
  output logic                          fifo_write_enable,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic [REQ_BITS-1:0]           grant_id,
  output logic                          busy
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e                state_q, state_d;
  logic [REQ_BITS-1:0]   grant_q, grant_d;
  logic [REQ_BITS-1:0]   last_q, last_d;
  logic [BURST_BITS-1:0] burst_q, burst_d;

  logic [REQ_BITS-1:0] winner;
  logic                found;
  logic                owner_valid;
  logic                wr;
  int unsigned         idx;

  // Search starts just after the last served requester, so it has lowest priority.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(last_q) + i) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx[REQ_BITS-1:0];
      end
    end
  end

  always_comb begin
    owner_valid       = req_valid[grant_q];
    wr                = (state_q == StGrant) && owner_valid && !fifo_full && !reset;
    fifo_write_enable = wr;
    req_ack           = wr ? (NUM_REQ'(1) << grant_q) : '0;
    fifo_data         = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
    grant_id          = grant_q;
    busy              = (state_q == StGrant);
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    burst_d = burst_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = winner;
          burst_d = '0;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (wr && (burst_q == BURST_BITS'(BURST_LEN - 1))) begin
          last_d  = grant_q;
          state_d = StIdle;
        end else if (wr) begin
          burst_d = burst_q + BURST_BITS'(1);
        end else if (!owner_valid) begin
          last_d  = grant_q;
          state_d = StIdle;
        end
        // Otherwise stalled on fifo_full: hold everything, no timeout.
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= REQ_BITS'(NUM_REQ - 1);
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench: hand-derived vector table for the directed scenarios,
// then random traffic against a behavioural reference model.
module tb_fifo_write_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int BL = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ack;
  logic             fifo_full;
  logic             fifo_write_enable;
  logic [DW-1:0]    fifo_data;
  logic [1:0]       grant_id;
  logic             busy;

  fifo_write_arbiter #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .REQ_BITS(2), .BURST_LEN(BL), .BURST_BITS(3)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_data          (req_data),
    .req_ack           (req_ack),
    .fifo_full         (fifo_full),
    .fifo_write_enable (fifo_write_enable),
    .fifo_data         (fifo_data),
    .grant_id          (grant_id),
    .busy              (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic       full;
    logic       we;
    logic [3:0] ack;
    logic [1:0] gid;
    logic       busy;
  } vec_t;

  vec_t tbl[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   wcnt[NR];

  // Reference model: whether a grant is open, who owns it, words served so far.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_count = 0;
  int m_last  = NR - 1;

  function automatic logic [31:0] word(input int i, input int n);
    return (32'(i) << 24) + 32'hA0 + 32'(n);
  endfunction

  function automatic void add(input logic rst, input logic [3:0] v, input logic full,
                              input logic we, input logic [3:0] ack, input logic [1:0] gid,
                              input logic bsy);
    vec_t r;
    r.rst = rst; r.v = v; r.full = full; r.we = we; r.ack = ack; r.gid = gid; r.busy = bsy;
    tbl.push_back(r);
  endfunction

  function automatic void model_expect(input logic rst, input logic [3:0] v, input logic full,
                                       output logic [3:0] ack, output logic we,
                                       output logic [1:0] gid, output logic bsy);
    we  = m_busy && v[m_owner] && !full && !rst;
    ack = we ? 4'(1 << m_owner) : 4'b0000;
    gid = 2'(m_owner);
    bsy = m_busy;
  endfunction

  function automatic void model_advance(input logic rst, input logic [3:0] v, input logic full);
    bit found = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_owner = 0; m_count = 0; m_last = NR - 1;
    end else if (!m_busy) begin
      for (int k = 1; k <= NR; k++) begin
        int c = (m_last + k) % NR;
        if (!found && v[c]) begin
          found = 1'b1; m_busy = 1'b1; m_owner = c; m_count = 0;
        end
      end
    end else if (v[m_owner] && !full) begin
      m_count++;
      if (m_count == BL) begin
        m_last = m_owner; m_busy = 1'b0;
      end
    end else if (!v[m_owner]) begin
      m_last = m_owner; m_busy = 1'b0;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic run_cycle(input logic rst, input logic [3:0] v, input logic full,
                           input logic [3:0] ack_e, input logic we_e, input logic [1:0] gid_e,
                           input logic busy_e, input string nm);
    @(negedge clock);
    reset     = rst;
    req_valid = v;
    fifo_full = full;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = word(i, wcnt[i]);
    #1;
    chk({nm, ".we"},   32'(fifo_write_enable), 32'(we_e));
    chk({nm, ".ack"},  32'(req_ack),           32'(ack_e));
    chk({nm, ".gid"},  32'(grant_id),          32'(gid_e));
    chk({nm, ".busy"}, 32'(busy),              32'(busy_e));
    chk({nm, ".data"}, fifo_data,              word(int'(gid_e), wcnt[gid_e]));
    // Producers advance to their next word once acked.
    for (int i = 0; i < NR; i++) if (ack_e[i]) wcnt[i]++;
    model_advance(rst, v, full);
  endtask

  initial begin
    logic [3:0] ack_e;
    logic       we_e;
    logic [1:0] gid_e;
    logic       busy_e;

    reset = 1'b1; req_valid = '0; fifo_full = 1'b0; req_data = '0;
    for (int i = 0; i < NR; i++) wcnt[i] = 0;

    // Reset then idle.
    add(1, 4'b0000, 0, 0, 4'b0000, 0, 0);
    add(1, 4'b0000, 0, 0, 4'b0000, 0, 0);
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0);
    // Single requester 2: arbitration gap, 4 writes, gap, 2 writes, release.
    add(0, 4'b0100, 0, 0, 4'b0000, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 4'b0100, 0, 1, 4'b0100, 2, 1);
    add(0, 4'b0100, 0, 0, 4'b0000, 2, 0);
    for (int k = 0; k < 2; k++) add(0, 4'b0100, 0, 1, 4'b0100, 2, 1);
    add(0, 4'b0000, 0, 0, 4'b0000, 2, 1);
    add(1, 4'b0000, 0, 0, 4'b0000, 2, 0);
    // Round-robin with all requesting: 0,1,2,3,0, reset in the final gap.
    add(0, 4'b1111, 0, 0, 4'b0000, 0, 0);
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 4; k++) add(0, 4'b1111, 0, 1, 4'(1 << (b % 4)), 2'(b % 4), 1);
      add(b == 4, 4'b1111, 0, 0, 4'b0000, 2'(b % 4), 0);
    end
    // Backpressure on requester 1 after 2 writes, 3-cycle stall, 2 more writes.
    add(0, 4'b0010, 0, 0, 4'b0000, 0, 0);
    for (int k = 0; k < 2; k++) add(0, 4'b0010, 0, 1, 4'b0010, 1, 1);
    for (int k = 0; k < 3; k++) add(0, 4'b0010, 1, 0, 4'b0000, 1, 1);
    for (int k = 0; k < 2; k++) add(0, 4'b0010, 0, 1, 4'b0010, 1, 1);
    // Early release by requester 3 after one word; requester 0 pending.
    add(0, 4'b1000, 0, 0, 4'b0000, 1, 0);
    add(0, 4'b1000, 0, 1, 4'b1000, 3, 1);
    add(0, 4'b0001, 0, 0, 4'b0000, 3, 1);
    add(0, 4'b0001, 0, 0, 4'b0000, 3, 0);
    add(0, 4'b0001, 0, 1, 4'b0001, 0, 1);
    add(1, 4'b0000, 0, 0, 4'b0000, 0, 1);
    // Reset in the cycle of requester 2's third word; requester 0 wins afterwards.
    add(0, 4'b0100, 0, 0, 4'b0000, 0, 0);
    for (int k = 0; k < 2; k++) add(0, 4'b0100, 0, 1, 4'b0100, 2, 1);
    add(1, 4'b0100, 0, 0, 4'b0000, 2, 1);
    add(0, 4'b0101, 0, 0, 4'b0000, 0, 0);
    add(0, 4'b0101, 0, 1, 4'b0001, 0, 1);

    foreach (tbl[i])
      run_cycle(tbl[i].rst, tbl[i].v, tbl[i].full, tbl[i].ack, tbl[i].we, tbl[i].gid,
                tbl[i].busy, $sformatf("tbl[%0d]", i));

    // Random traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      logic       r_rst;
      logic [3:0] r_v;
      logic       r_full;
      r_rst  = ($urandom_range(0, 99) == 0);
      r_v    = 4'($urandom) | 4'($urandom);
      r_full = ($urandom_range(0, 3) == 0);
      model_expect(r_rst, r_v, r_full, ack_e, we_e, gid_e, busy_e);
      run_cycle(r_rst, r_v, r_full, ack_e, we_e, gid_e, busy_e, $sformatf("rnd[%0d]", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
